// File: rtl/instr_encoder.sv
// RV32I mnemonic-to-machine-word encoder feeding a small word/address FIFO.
// Define IMM_RANGE_CHECK_EN to drop requests whose immediate does not fit its field.
module instr_encoder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            op_sel,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S,
    FMT_B, FMT_J, FMT_U, FMT_SYS
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        legal;
  logic        rng_bad;
  logic [31:0] word;

  logic [DATA_WIDTH-1:0] mem_instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_q  [DEPTH];

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic                  err_q, err_d;

  logic accept, push, pop;

  always_comb begin
    f3 = 3'd0;
    unique case (op_sel)
      6'd2, 6'd11:                f3 = 3'd7;
      6'd3, 6'd12:                f3 = 3'd6;
      6'd4, 6'd13, 6'd21, 6'd26:  f3 = 3'd4;
      6'd5, 6'd14, 6'd25:         f3 = 3'd1;
      6'd6, 6'd7, 6'd15, 6'd16,
      6'd27:                      f3 = 3'd5;
      6'd8, 6'd17, 6'd20, 6'd23:  f3 = 3'd2;
      6'd9, 6'd18:                f3 = 3'd3;
      6'd28:                      f3 = 3'd6;
      6'd29:                      f3 = 3'd7;
      default:                    f3 = 3'd0;
    endcase
  end

  assign f7 = (op_sel == 6'd1 || op_sel == 6'd7 ||
               op_sel == 6'd16) ? 7'h20 : 7'h00;

  always_comb begin
    fmt   = FMT_R;
    opc   = 7'h00;
    legal = 1'b1;
    unique case (1'b1)
      (op_sel <= 6'd9): begin
        fmt = FMT_R;
        opc = 7'b0110011;
      end
      (op_sel >= 6'd10 && op_sel <= 6'd18): begin
        fmt = (op_sel >= 6'd14 && op_sel <= 6'd16) ? FMT_SH : FMT_I;
        opc = 7'b0010011;
      end
      (op_sel >= 6'd19 && op_sel <= 6'd21): begin
        fmt = FMT_I;
        opc = 7'b0000011;
      end
      (op_sel == 6'd22 || op_sel == 6'd23): begin
        fmt = FMT_S;
        opc = 7'b0100011;
      end
      (op_sel >= 6'd24 && op_sel <= 6'd29): begin
        fmt = FMT_B;
        opc = 7'b1100011;
      end
      (op_sel == 6'd30): begin
        fmt = FMT_J;
        opc = 7'b1101111;
      end
      (op_sel == 6'd31): begin
        fmt = FMT_I;
        opc = 7'b1100111;
      end
      (op_sel == 6'd32): begin
        fmt = FMT_U;
        opc = 7'b0110111;
      end
      (op_sel == 6'd33): begin
        fmt = FMT_U;
        opc = 7'b0010111;
      end
      (op_sel == 6'd34 || op_sel == 6'd35): begin
        fmt = FMT_SYS;
        opc = 7'b1110011;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    word = 32'h0;
    unique case (fmt)
      FMT_R:  word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I:  word = {imm[11:0], rs1, f3, rd, opc};
      FMT_SH: word = {f7, imm[4:0], rs1, f3, rd, opc};
      FMT_S:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B:  word = {imm[12], imm[10:5], rs2, rs1, f3,
                      imm[4:1], imm[11], opc};
      FMT_J:  word = {imm[20], imm[10:1], imm[11],
                      imm[19:12], rd, opc};
      FMT_U:  word = {imm[31:12], rd, opc};
      FMT_SYS: word = (op_sel == 6'd35) ? 32'h00100073
                                        : 32'h00000073;
      default: word = 32'h0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = signed'(imm);

  always_comb begin
    rng_bad = 1'b0;
    unique case (fmt)
      FMT_I, FMT_S: rng_bad = (simm < -2048) || (simm > 2047);
      FMT_B:  rng_bad = (simm < -4096) || (simm > 4095) || imm[0];
      FMT_J:  rng_bad = (simm < -1048576) || (simm > 1048575) ||
                        imm[0];
      FMT_SH: rng_bad = |imm[31:5];
      FMT_U:  rng_bad = |imm[11:0];
      default: rng_bad = 1'b0;
    endcase
    if (!legal) rng_bad = 1'b0;
  end
`else
  assign rng_bad = 1'b0;
`endif

  assign in_ready  = rst_n && !clear && (cnt_q != (PW+1)'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal && !rng_bad;
  assign pop       = out_valid && out_ready && !clear;

  assign out_instr = out_valid ? mem_instr_q[rptr_q] : hold_instr_q;
  assign out_addr  = out_valid ? mem_addr_q[rptr_q]  : hold_addr_q;
  assign err       = err_q;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    hold_instr_d = hold_instr_q;
    hold_addr_d  = hold_addr_q;
    err_d        = err_q || (accept && (!legal || rng_bad));
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      addr_d = BASE_ADDR;
    end else begin
      if (push) begin
        wptr_d = wptr_q + 1'b1;
        addr_d = addr_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rptr_d       = rptr_q + 1'b1;
        hold_instr_d = mem_instr_q[rptr_q];
        hold_addr_d  = mem_addr_q[rptr_q];
      end
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      if (pop && !push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      addr_q       <= BASE_ADDR;
      hold_instr_q <= '0;
      hold_addr_q  <= BASE_ADDR;
      err_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      hold_instr_q <= hold_instr_d;
      hold_addr_q  <= hold_addr_d;
      err_q        <= err_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wptr_q] <= word;
      mem_addr_q[wptr_q]  <= addr_q;
    end
  end

endmodule
